memory_read_ctrl: RTL and testbench

MEMORY_READ_CTRL -- requirements
Module: memory_read_ctrl

---
 rtl/mem_pkg.sv | 26 ++
 rtl/memory_read_ctrl.sv | 147 ++++++++++++++
 tb/tb_memory_read_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared block-memory definitions: geometry of a storage block and the
// footer that links blocks into a frame chain.
package mem_pkg;

    localparam int ADDR_W        = 8;
    localparam int BLOCK_BYTES   = 64;
    localparam int BLOCK_BITS    = BLOCK_BYTES * 8;
    localparam int PAYLOAD_BYTES = 62;
    localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;
    localparam int FOOTER_BITS   = BLOCK_BITS - PAYLOAD_BITS;

    // Footer occupies the low 16 bits of a block; eop marks the last block
    // of a frame, next_idx links to the following block otherwise.
    typedef struct packed {
        logic                            eop;
        logic [FOOTER_BITS-2-ADDR_W:0]   rsvd;
        logic [ADDR_W-1:0]               next_idx;
    } footer_t;

    // Byte k of a payload, first-written byte most significant.
    function automatic logic [7:0] payload_byte(input logic [PAYLOAD_BITS-1:0] payload,
                                                input int                      k);
        return payload[PAYLOAD_BITS-1-8*k -: 8];
    endfunction

endpackage

// File: rtl/memory_read_ctrl.sv
// Frame read controller: walks a linked chain of memory blocks, streams
// each block's payload as bytes, and returns every block to the free list
// once its last byte has been accepted by the sink.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a frame request (head block index)
// S_RD_REQ  | read request for curr_idx held until memory accepts it
// S_RD_WAIT | waiting for the read data pulse
// S_STREAM  | emitting the 62 payload bytes of the current block
// S_FREE    | returning curr_idx to the free list, held until granted
module memory_read_ctrl
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     start_idx_i,
    output logic                  start_ready_o,
    input  logic                  mem_ready_i,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    output logic [7:0]            data_o,
    output logic                  data_valid_o,
    output logic                  data_begin_o,
    output logic                  data_end_o,
    input  logic                  data_ready_i,
    output logic                  fl_free_req_o,
    output logic [ADDR_W-1:0]     fl_free_idx_o,
    input  logic                  fl_free_gnt_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_STREAM,
        S_FREE
    } state_t;

    localparam int               CNT_W     = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_W-1:0]       r_curr_idx;
    logic [ADDR_W-1:0]       r_next_idx;
    logic [PAYLOAD_BITS-1:0] r_payload;
    logic                    r_eop;
    logic                    r_head;
    logic [CNT_W-1:0]        r_byte_cnt;

    footer_t                 w_footer;
    logic                    w_unused_rsvd;
    logic                    w_start_acc;
    logic                    w_byte_acc;
    logic                    w_last_acc;

    assign w_footer      = footer_t'(mem_rdata_i[FOOTER_BITS-1:0]);
    assign w_unused_rsvd = ^w_footer.rsvd;
    assign w_start_acc   = (r_state == S_IDLE) && start_i;
    assign w_byte_acc    = (r_state == S_STREAM) && data_ready_i;
    assign w_last_acc    = w_byte_acc && (r_byte_cnt == LAST_BYTE);

    // State register; reset abandons any frame in flight without freeing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; handshake inputs only matter in their own state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start_i)       w_next_state = S_RD_REQ;
            S_RD_REQ:  if (mem_ready_i)   w_next_state = S_RD_WAIT;
            S_RD_WAIT: if (mem_rvalid_i)  w_next_state = S_STREAM;
            S_STREAM:  if (w_last_acc)    w_next_state = S_FREE;
            S_FREE:    if (fl_free_gnt_i) w_next_state = r_eop ? S_IDLE : S_RD_REQ;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state; everything not active in a state reads zero.
    always_comb begin
        start_ready_o = 1'b0;
        mem_re_o      = 1'b0;
        mem_addr_o    = '0;
        data_o        = '0;
        data_valid_o  = 1'b0;
        data_begin_o  = 1'b0;
        data_end_o    = 1'b0;
        fl_free_req_o = 1'b0;
        fl_free_idx_o = '0;
        case (r_state)
            S_IDLE: start_ready_o = 1'b1;
            S_RD_REQ: begin
                mem_re_o   = 1'b1;
                mem_addr_o = r_curr_idx;
            end
            S_STREAM: begin
                data_valid_o = 1'b1;
                data_o       = payload_byte(r_payload, int'(r_byte_cnt));
                data_begin_o = r_head && (r_byte_cnt == '0);
                data_end_o   = r_eop && (r_byte_cnt == LAST_BYTE);
            end
            S_FREE: begin
                fl_free_req_o = 1'b1;
                fl_free_idx_o = r_curr_idx;
            end
            default: ;
        endcase
    end

    // Block datapath: current index, captured payload/footer, byte counter.
    // The counter parks on the last byte rather than wrapping inside a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_curr_idx <= '0;
            r_next_idx <= '0;
            r_payload  <= '0;
            r_eop      <= 1'b0;
            r_head     <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_curr_idx <= start_idx_i;
                r_head     <= 1'b1;
            end
            if ((r_state == S_RD_WAIT) && mem_rvalid_i) begin
                r_payload  <= mem_rdata_i[BLOCK_BITS-1:FOOTER_BITS];
                r_next_idx <= w_footer.next_idx;
                r_eop      <= w_footer.eop;
                r_byte_cnt <= '0;
            end
            if (w_byte_acc) begin
                if (w_last_acc) r_head     <= 1'b0;
                else            r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if ((r_state == S_FREE) && fl_free_gnt_i && !r_eop)
                r_curr_idx <= r_next_idx;
        end
    end

endmodule

// File: tb/tb_memory_read_ctrl.sv
// Bench for memory_read_ctrl: a cycle-stepped environment plays memory,
// sink and free list at once, with expected bytes and block order derived
// from a behavioural memory image and the frame's block chain.
module tb_memory_read_ctrl;
    import mem_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start_i;
    logic [ADDR_W-1:0]     start_idx_i;
    logic                  start_ready_o;
    logic                  mem_ready_i;
    logic                  mem_re_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic                  mem_rvalid_i;
    logic [BLOCK_BITS-1:0] mem_rdata_i;
    logic [7:0]            data_o;
    logic                  data_valid_o;
    logic                  data_begin_o;
    logic                  data_end_o;
    logic                  data_ready_i;
    logic                  fl_free_req_o;
    logic [ADDR_W-1:0]     fl_free_idx_o;
    logic                  fl_free_gnt_i;

    memory_read_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .start_idx_i   (start_idx_i),
        .start_ready_o (start_ready_o),
        .mem_ready_i   (mem_ready_i),
        .mem_re_o      (mem_re_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .data_begin_o  (data_begin_o),
        .data_end_o    (data_end_o),
        .data_ready_i  (data_ready_i),
        .fl_free_req_o (fl_free_req_o),
        .fl_free_idx_o (fl_free_idx_o),
        .fl_free_gnt_i (fl_free_gnt_i)
    );

    always #5 clk = ~clk;

    int                    n_vec = 0;
    int                    n_err = 0;
    string                 cur_name = "init";
    logic [BLOCK_BITS-1:0] mem [256];
    int                    g_chain [$];
    logic [7:0]            exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_name, tag, obs, exp);
        end
    endtask

    function automatic logic [BLOCK_BITS-1:0] rand_block();
        logic [BLOCK_BITS-1:0] b;
        for (int i = 0; i < BLOCK_BITS / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic idle_inputs();
        start_i       = 1'b0;
        start_idx_i   = '0;
        mem_ready_i   = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        data_ready_i  = 1'b0;
        fl_free_gnt_i = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_start_ready", start_ready_o, 1);
        chk("rst_mem_re",      mem_re_o, 0);
        chk("rst_mem_addr",    mem_addr_o, 0);
        chk("rst_data",        data_o, 0);
        chk("rst_valid",       data_valid_o, 0);
        chk("rst_begin",       data_begin_o, 0);
        chk("rst_end",         data_end_o, 0);
        chk("rst_free_req",    fl_free_req_o, 0);
        chk("rst_free_idx",    fl_free_idx_o, 0);
    endtask

    // Link the chain through the footers of the memory image.
    task automatic link_chain();
        int n = g_chain.size();
        for (int i = 0; i < n; i++) begin
            mem[g_chain[i]][15]   = (i == n - 1);
            mem[g_chain[i]][14:8] = 7'h00;
            mem[g_chain[i]][7:0]  = (i == n - 1) ? 8'($urandom) : 8'(g_chain[i+1]);
        end
    endtask

    task automatic random_chain(input int n);
        g_chain.delete();
        while (g_chain.size() < n) begin
            int  c   = $urandom_range(0, 255);
            bit  dup = 0;
            foreach (g_chain[j]) if (g_chain[j] == c) dup = 1;
            if (!dup) g_chain.push_back(c);
        end
        link_chain();
    endtask

    task automatic run_frame(input int rdy_wait, input int lat, input int gnt_dly,
                             input int sink_mode, input int abort_at);
        int                n          = g_chain.size();
        int                rd_i       = 0;
        int                fr_i       = 0;
        int                popped     = 0;
        int                total      = 0;
        int                re_wait    = 0;
        int                gnt_wait   = 0;
        int                pend       = 0;
        int                cyc        = 0;
        bit                pend_act   = 0;
        bit                prev_re    = 0;
        bit                exp_stream = 0;
        bit                done       = 0;
        logic [ADDR_W-1:0] prev_addr  = '0;

        exp_q.delete();
        foreach (g_chain[i])
            for (int k = 0; k < PAYLOAD_BYTES; k++)
                exp_q.push_back(mem[g_chain[i]][BLOCK_BITS-1-8*k -: 8]);
        total = exp_q.size();

        @(negedge clk);
        idle_inputs();
        chk("idle_ready", start_ready_o, 1);
        start_i     = 1'b1;
        start_idx_i = ADDR_W'(g_chain[0]);

        while (!done && cyc < 8000) begin
            @(negedge clk);
            cyc++;

            if (abort_at >= 0 && popped == abort_at && data_valid_o) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs();
                idle_inputs();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            if (exp_stream) begin
                chk("stream_1cyc_after_rvalid", data_valid_o, 1);
                exp_stream = 0;
            end

            // Stray starts while busy must be ignored.
            start_i     = start_ready_o ? 1'b0 : 1'($urandom_range(0, 1));
            start_idx_i = ADDR_W'($urandom);

            // Read data return, plus stray pulses while no read is outstanding.
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (pend_act) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem[g_chain[rd_i-1]];
                    pend_act     = 0;
                    exp_stream   = 1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rand_block();
            end

            // Read request acceptance.
            mem_ready_i = 1'($urandom_range(0, 1));
            if (prev_re) begin
                chk("re_held",   mem_re_o, 1);
                chk("addr_held", mem_addr_o, prev_addr);
            end
            if (mem_re_o) begin
                if (re_wait >= rdy_wait) begin
                    mem_ready_i = 1'b1;
                    chk("rd_addr", mem_addr_o, (rd_i < n) ? g_chain[rd_i] : 32'hFFFF_FFFF);
                    rd_i++;
                    pend     = lat;
                    pend_act = 1;
                    re_wait  = 0;
                    prev_re  = 0;
                end else begin
                    mem_ready_i = 1'b0;
                    re_wait++;
                    prev_re   = 1;
                    prev_addr = mem_addr_o;
                end
            end else begin
                prev_re = 0;
            end

            // Byte sink.
            data_ready_i = 1'($urandom_range(0, 1));
            if (data_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", data_valid_o, 0);
                end else begin
                    chk("data",  data_o, exp_q[0]);
                    chk("begin", data_begin_o, popped == 0);
                    chk("end",   data_end_o, popped == total - 1);
                    case (sink_mode)
                        0:       data_ready_i = 1'b1;
                        1:       data_ready_i = 1'(cyc % 2);
                        default: data_ready_i = 1'($urandom_range(0, 1));
                    endcase
                    if (data_ready_i) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end

            // Free list.
            fl_free_gnt_i = 1'b0;
            if (fl_free_req_o) begin
                chk("free_idx", fl_free_idx_o, (fr_i < n) ? g_chain[fr_i] : 32'hFFFF_FFFF);
                chk("no_read_during_free", mem_re_o, 0);
                if (gnt_wait >= gnt_dly) begin
                    fl_free_gnt_i = 1'b1;
                    chk("free_after_last_byte", popped, PAYLOAD_BYTES * (fr_i + 1));
                    fr_i++;
                    gnt_wait = 0;
                    if (fr_i == n) done = 1;
                end else begin
                    gnt_wait++;
                end
            end else begin
                fl_free_gnt_i = 1'($urandom_range(0, 1));
            end
        end

        chk("frame_done", done, 1);
        @(negedge clk);
        idle_inputs();
        chk("idle_after_frame", start_ready_o, 1);
        chk("reads_issued", rd_i, n);
        chk("bytes_streamed", popped, total);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        foreach (mem[i]) mem[i] = rand_block();
        repeat (3) @(negedge clk);
        cur_name = "reset";
        chk_reset_outputs();
        rst_n = 1'b1;

        cur_name = "single_block";
        g_chain = '{5};
        for (int k = 0; k < PAYLOAD_BYTES; k++) mem[5][BLOCK_BITS-1-8*k -: 8] = 8'(k);
        link_chain();
        run_frame(0, 1, 0, 0, -1);

        cur_name = "chain_5_9_2";
        g_chain = '{5, 9, 2};
        link_chain();
        run_frame(0, 1, 0, 0, -1);

        cur_name = "sink_toggle";
        random_chain(3);
        run_frame(0, 1, 0, 1, -1);

        cur_name = "mem_stall";
        random_chain(2);
        run_frame(4, 3, 0, 0, -1);

        cur_name = "gnt_delay";
        random_chain(3);
        run_frame(0, 2, 5, 0, -1);

        cur_name = "reset_mid_frame";
        random_chain(3);
        run_frame(1, 2, 1, 0, PAYLOAD_BYTES + 20);

        cur_name = "after_reset";
        random_chain(2);
        run_frame(0, 1, 0, 2, -1);

        for (int f = 0; f < 20; f++) begin
            cur_name = $sformatf("random_%0d", f);
            foreach (mem[i]) mem[i] = rand_block();
            random_chain($urandom_range(1, 4));
            run_frame($urandom_range(0, 5), $urandom_range(1, 6),
                      $urandom_range(0, 6), $urandom_range(0, 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
